// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types for the memory arbiter slice.
//   arb_state_e : arbiter FSM states (IDLE, ISSUE, WAIT)
//   owner_e     : which pipeline stage owns the outstanding transaction
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Purely combinational winner select between the fetch and memory stages.
// Tie-break policy is chosen by the MEM_ARB_RR_EN macro:
//   defined   : round-robin, the stage not granted most recently wins a tie
//   undefined : fixed priority, the memory stage always wins a tie
// Ports:
//   i_ifReq      in  fetch stage request
//   i_memReq     in  memory stage request
//   i_lastOwner  in  owner of the most recent grant
//   o_valid      out at least one request present
//   o_winner     out selected owner (meaningful only when o_valid)
import mem_arb_pkg::*;

module mem_arb_pick (
  input  logic   i_ifReq,
  input  logic   i_memReq,
  input  owner_e i_lastOwner,
  output logic   o_valid,
  output owner_e o_winner
);

  // Single requester wins outright; only a tie consults the policy.
  always_comb begin
    o_valid  = i_ifReq | i_memReq;
    o_winner = OWNER_IF;
    if (i_ifReq && i_memReq) begin
`ifdef MEM_ARB_RR_EN
      o_winner = (i_lastOwner == OWNER_IF) ? OWNER_MEM : OWNER_IF;
`else
      o_winner = OWNER_MEM;
`endif
    end else if (i_memReq) begin
      o_winner = OWNER_MEM;
    end
  end

`ifndef MEM_ARB_RR_EN
  // Fixed priority has no use for history; keep the port uniform.
  logic w_unusedLastOwner;
  assign w_unusedLastOwner = i_lastOwner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates a fetch-stage read port and a memory-stage read/write port onto
// a single downstream bus with exactly one transaction outstanding.
// Tie-break policy selected by macro MEM_ARB_RR_EN (see mem_arb_pick).
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   if_req/if_addr                  fetch request, held until if_gnt
//   if_gnt/if_rvalid                fetch accept / response pulse
//   mem_req/mem_we/mem_addr/wdata   memory stage request, held until mem_gnt
//   mem_gnt/mem_rvalid              memory accept / response (or store ack)
//   rdata                           shared response data
//   bus_req/we/addr/wdata           downstream request
//   bus_ready                       downstream accept
//   bus_resp_valid/bus_resp_data    downstream response
//   busy                            high whenever not IDLE
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      if_req,
  input  logic [ADDR_WIDTH-1:0]     if_addr,
  output logic                      if_gnt,
  output logic                      if_rvalid,
  input  logic                      mem_req,
  input  logic                      mem_we,
  input  logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [BUS_DATA_WIDTH-1:0] mem_wdata,
  output logic                      mem_gnt,
  output logic                      mem_rvalid,
  output logic [BUS_DATA_WIDTH-1:0] rdata,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [ADDR_WIDTH-1:0]     bus_addr,
  output logic [BUS_DATA_WIDTH-1:0] bus_wdata,
  input  logic                      bus_ready,
  input  logic                      bus_resp_valid,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp_data,
  output logic                      busy
);

  arb_state_e r_state;
  arb_state_e w_nextState;
  owner_e     r_owner;
  owner_e     r_lastOwner;
  owner_e     w_winner;
  logic       w_anyReq;
  logic       w_grant;
  logic       w_respTake;

  logic [ADDR_WIDTH-1:0]     r_addr;
  logic                      r_we;
  logic [BUS_DATA_WIDTH-1:0] r_wdata;
  logic [BUS_DATA_WIDTH-1:0] r_rdata;
  logic                      r_ifRvalid;
  logic                      r_memRvalid;

  mem_arb_pick u_pick (
    .i_ifReq     (if_req),
    .i_memReq    (mem_req),
    .i_lastOwner (r_lastOwner),
    .o_valid     (w_anyReq),
    .o_winner    (w_winner)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A grant only happens from IDLE, which is also the
  // cycle rvalid pulses, giving back-to-back throughput of one per 3 cycles.
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_respTake  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_grant     = 1'b1;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_ready) w_nextState = WAIT;
      end
      WAIT: begin
        if (bus_resp_valid) begin
          w_respTake  = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Capture the winner's operands at the grant edge; fetch is always a read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_owner     <= OWNER_IF;
      r_lastOwner <= OWNER_IF;
    end else if (w_grant) begin
      r_owner     <= w_winner;
      r_lastOwner <= w_winner;
      if (w_winner == OWNER_MEM) begin
        r_addr  <= mem_addr;
        r_we    <= mem_we;
        r_wdata <= mem_wdata;
      end else begin
        r_addr  <= if_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
      end
    end
  end

  // Response capture; rvalid is a registered one-cycle pulse to the owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata     <= '0;
      r_ifRvalid  <= 1'b0;
      r_memRvalid <= 1'b0;
    end else begin
      r_ifRvalid  <= w_respTake && (r_owner == OWNER_IF);
      r_memRvalid <= w_respTake && (r_owner == OWNER_MEM);
      if (w_respTake) r_rdata <= bus_resp_data;
    end
  end

  // Grants are gated by reset_n so they read zero during reset even while
  // requests are held; bus fields are zeroed outside ISSUE.
  always_comb begin
    if_gnt     = reset_n && w_grant && (w_winner == OWNER_IF);
    mem_gnt    = reset_n && w_grant && (w_winner == OWNER_MEM);
    bus_req    = (r_state == ISSUE);
    bus_we     = bus_req && r_we;
    bus_addr   = bus_req ? r_addr : '0;
    bus_wdata  = bus_req ? r_wdata : '0;
    busy       = (r_state != IDLE);
    if_rvalid  = r_ifRvalid;
    mem_rvalid = r_memRvalid;
    rdata      = r_rdata;
  end

endmodule
